// File: rtl/adder_core.sv
// Registered unsigned two-operand adder with carry-out and a result-valid flag.
// One-cycle latency, one result per cycle, no backpressure.
module adder_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             out_valid
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [SUM_W-1:0] sum_c;

  // Zero-extend both operands so bit WIDTH of the sum is the carry-out.
  always_comb begin
    sum_c = SUM_W'(in0) + SUM_W'(in1);
  end

  // Result only loads when in_valid is high, so idle-cycle operands never reach out/carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        {carry, out} <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_core.sv
// Self-checking bench for adder_core: directed cases, exhaustive sweep and random
// stimulus against an integer-arithmetic reference model.
module tb_adder_core;

  localparam int unsigned W = 4;
  localparam int unsigned MODV = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [W-1:0] out;
  logic         carry;
  logic         out_valid;

  int vectors;
  int miscompares;

  // Reference state: last accepted sum and validity of the most recent cycle.
  int exp_out;
  int exp_carry;
  int exp_valid;

  adder_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .out       (out),
    .carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out"},   64'(out),       64'(exp_out));
    check({tag, ".carry"}, 64'(carry),     64'(exp_carry));
    check({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
  endtask

  // Drive one cycle of inputs, let one edge pass, then compare against the model.
  task automatic step(input string tag, input logic v, input int a, input int b);
    int s;
    @(negedge clk);
    in_valid = v;
    in0      = W'(a);
    in1      = W'(b);
    @(posedge clk);
    #1;
    if (v) begin
      s         = a + b;
      exp_out   = s % MODV;
      exp_carry = s / MODV;
    end
    exp_valid = int'(v);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    exp_out   = 0;
    exp_carry = 0;
    exp_valid = 0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();

    // Reset held with live inputs: outputs must stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in0      = W'(5);
    in1      = W'(3);
    #2;
    check_outputs("reset_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_outputs("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;

    step("basic", 1'b1, 3, 4);
    step("wrap1", 1'b1, 15, 1);
    step("wrap2", 1'b1, 15, 15);

    for (int a = 0; a < int'(MODV); a++)
      for (int b = 0; b < int'(MODV); b++)
        step("exh", 1'b1, a, b);

    step("hold_load", 1'b1, 9, 8);
    step("hold_idle", 1'b0, 2, 2);
    // X operands while idle must not disturb the held result.
    @(negedge clk);
    in_valid = 1'b0;
    in0      = 'x;
    in1      = 'x;
    @(posedge clk);
    #1;
    exp_valid = 0;
    check_outputs("hold_x");

    for (int i = 0; i < 200; i++)
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, MODV - 1)),
           int'($urandom_range(0, MODV - 1)));

    // Async reset between edges, then release and confirm one-cycle latency.
    step("pre_rst", 1'b1, 12, 7);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("mid_rst");
    @(posedge clk);
    #1;
    check_outputs("mid_rst_hold");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in0      = W'(6);
    in1      = W'(7);
    #1;
    check_outputs("post_rst_pre_edge");
    @(posedge clk);
    #1;
    exp_out   = 13;
    exp_carry = 0;
    exp_valid = 1;
    check_outputs("post_rst_first");
    step("post_rst_next", 1'b1, 8, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
